// File: rtl/sseg_pkg.sv
// Shared constants for the 7-segment scan reader: segment bit order,
// segment patterns for 0..F and blank, and the reader FSM state encoding.
package sseg_pkg;

    // Bit positions of segments a..g within the 7-bit segment bus
    localparam int unsigned SEG_A = 6;
    localparam int unsigned SEG_B = 5;
    localparam int unsigned SEG_C = 4;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 2;
    localparam int unsigned SEG_F_BIT = 1;
    localparam int unsigned SEG_G = 0;

    // Active-high segment patterns, {a,b,c,d,e,f,g}
    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_A_PAT = 7'h77;
    localparam logic [6:0] SEG_B_PAT = 7'h1F;
    localparam logic [6:0] SEG_C_PAT = 7'h4E;
    localparam logic [6:0] SEG_D_PAT = 7'h3D;
    localparam logic [6:0] SEG_E_PAT = 7'h4F;
    localparam logic [6:0] SEG_F_PAT = 7'h47;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Reader FSM states
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

endpackage

// File: rtl/sseg_pattern_decode.sv
// Combinational 7-segment pattern to nibble decoder.
// Hex letters A..F are accepted only when SSEG_READER_HEX_EN is defined;
// otherwise they decode as invalid like any other unknown pattern.
module sseg_pattern_decode
    import sseg_pkg::*;
(
    input  logic [6:0] seg,
    output logic       pat_ok,
    output logic [3:0] nibble
);

    // Table lookup; unknown patterns (including blank) give nibble 0, pat_ok 0
    always_comb begin
        pat_ok = 1'b1;
        nibble = '0;
        case (seg)
            SEG_0: nibble = 4'h0;
            SEG_1: nibble = 4'h1;
            SEG_2: nibble = 4'h2;
            SEG_3: nibble = 4'h3;
            SEG_4: nibble = 4'h4;
            SEG_5: nibble = 4'h5;
            SEG_6: nibble = 4'h6;
            SEG_7: nibble = 4'h7;
            SEG_8: nibble = 4'h8;
            SEG_9: nibble = 4'h9;
`ifdef SSEG_READER_HEX_EN
            SEG_A_PAT: nibble = 4'hA;
            SEG_B_PAT: nibble = 4'hB;
            SEG_C_PAT: nibble = 4'hC;
            SEG_D_PAT: nibble = 4'hD;
            SEG_E_PAT: nibble = 4'hE;
            SEG_F_PAT: nibble = 4'hF;
`endif
            default: begin
                nibble = '0;
                pat_ok = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/sseg_scan_reader.sv
// Receive side of a multiplexed 7-segment bus. Waits for each selected digit
// to hold stable for SETTLE cycles, decodes it once per select change, and
// publishes a full NDIG-digit frame with a one-cycle valid pulse.
// Optional hex letter decoding: define SSEG_READER_HEX_EN.
module sseg_scan_reader
    import sseg_pkg::*;
#(
    parameter int unsigned NDIG   = 4,
    parameter int unsigned SETTLE = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          seg_i,
    input  logic [NDIG-1:0]     an_n_i,
    output logic [4*NDIG-1:0]   value_o,
    output logic [NDIG-1:0]     digit_err_o,
    output logic                frame_valid_o
);

    localparam int unsigned CW = $clog2(SETTLE + 1);

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [NDIG-1:0]     lat_an;
    logic [6:0]          lat_seg;
    logic [NDIG-1:0]     seen;
    logic [4*NDIG-1:0]   shadow;
    logic [NDIG-1:0]     shadow_err;

    logic                pat_ok;
    logic [3:0]          nibble;
    logic                sel_valid;
    logic                inputs_same;
    logic                last_cnt;
    logic [4*NDIG-1:0]   shadow_m;
    logic [NDIG-1:0]     err_m;
    logic [NDIG-1:0]     seen_m;

    // Latched pattern equals the live one on a capture edge
    sseg_pattern_decode u_decode (
        .seg    (lat_seg),
        .pat_ok (pat_ok),
        .nibble (nibble)
    );

    // Select qualification, stability compare and shadow merge for the digit being captured
    always_comb begin
        sel_valid   = $onehot(~an_n_i);
        inputs_same = (an_n_i == lat_an) && (seg_i == lat_seg);
        last_cnt    = (cnt == CW'(SETTLE - 1));
        shadow_m    = shadow;
        err_m       = shadow_err;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (!lat_an[i]) begin
                shadow_m[4*i +: 4] = nibble;
                err_m[i]           = ~pat_ok;
            end
        end
        seen_m = seen | ~lat_an;
    end

    // Reader FSM with settle counter, shadow capture and frame publication
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            cnt           <= '0;
            lat_an        <= '1;
            lat_seg       <= '0;
            seen          <= '0;
            shadow        <= '0;
            shadow_err    <= '0;
            value_o       <= '0;
            digit_err_o   <= '0;
            frame_valid_o <= 1'b0;
        end else begin
            frame_valid_o <= 1'b0;
            if (!sel_valid) begin
                // Bad select aborts the digit but keeps partial frame progress
                state <= S_IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        lat_an  <= an_n_i;
                        lat_seg <= seg_i;
                        cnt     <= '0;
                        state   <= S_SETTLE;
                    end
                    S_SETTLE: begin
                        if (!inputs_same) begin
                            lat_an  <= an_n_i;
                            lat_seg <= seg_i;
                            cnt     <= '0;
                        end else if (last_cnt) begin
                            shadow     <= shadow_m;
                            shadow_err <= err_m;
                            state      <= S_HOLD;
                            if (&seen_m) begin
                                value_o       <= shadow_m;
                                digit_err_o   <= err_m;
                                frame_valid_o <= 1'b1;
                                seen          <= '0;
                            end else begin
                                seen <= seen_m;
                            end
                        end else if (cnt < CW'(SETTLE)) begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_HOLD: begin
                        if (an_n_i != lat_an) begin
                            lat_an  <= an_n_i;
                            lat_seg <= seg_i;
                            cnt     <= '0;
                            state   <= S_SETTLE;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sseg_scan_reader.sv
// Directed bench for sseg_scan_reader (NDIG=4, SETTLE=3). Expected frames are
// queued as the scan is driven and checked when frame_valid_o pulses.
module tb_sseg_scan_reader;
    import sseg_pkg::*;

    localparam int unsigned NDIG   = 4;
    localparam int unsigned SETTLE = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg_i;
    logic [3:0]  an_n_i;
    logic [15:0] value_o;
    logic [3:0]  digit_err_o;
    logic        frame_valid_o;

    typedef struct packed {
        logic [15:0] v;
        logic [3:0]  e;
    } frame_t;

    frame_t exp_q[$];
    frame_t f_exp;
    int     n_checks    = 0;
    int     n_pass      = 0;
    int     n_pulses    = 0;
    int     exp_pulses  = 0;

    always #5 clk = ~clk;

    sseg_scan_reader #(
        .NDIG   (NDIG),
        .SETTLE (SETTLE)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .seg_i         (seg_i),
        .an_n_i        (an_n_i),
        .value_o       (value_o),
        .digit_err_o   (digit_err_o),
        .frame_valid_o (frame_valid_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic expect_frame(input logic [15:0] v, input logic [3:0] e);
        exp_q.push_back('{v: v, e: e});
        exp_pulses++;
    endtask

    // Select digit k showing pattern s for n cycles; starts and ends on a negedge
    task automatic show(input int k, input logic [6:0] s, input int n);
        logic [3:0] one;
        one    = 4'b0001 << k;
        an_n_i = ~one;
        seg_i  = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        an_n_i = 4'hF;
        seg_i  = SEG_BLANK;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input string tag);
        chk({tag, "_queue_empty"}, exp_q.size(), 0);
        chk({tag, "_pulse_count"}, n_pulses, exp_pulses);
    endtask

    // Scoreboard: every frame pulse must match the oldest queued frame
    always @(negedge clk) begin
        if (rst_n && frame_valid_o) begin
            n_pulses++;
            chk("frame_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                f_exp = exp_q.pop_front();
                chk("frame_value", value_o, f_exp.v);
                chk("frame_err", digit_err_o, f_exp.e);
            end
        end
    end

    initial begin
        rst_n  = 1'b0;
        an_n_i = 4'hF;
        seg_i  = SEG_BLANK;
        repeat (3) @(negedge clk);
        chk("reset_value", value_o, 0);
        chk("reset_err", digit_err_o, 0);
        chk("reset_fv", frame_valid_o, 0);
        chk("reset_state", dut.state === S_IDLE, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic scan
        show(0, 7'h79, 6);
        show(1, 7'h30, 6);
        show(2, 7'h6D, 6);
        expect_frame(16'h0213, 4'b0000);
        show(3, 7'h7E, 6);
        idle(4);
        drain("t1");

        // Transient 8 on digit 1 is not captured, 9 is
        show(0, 7'h7E, 6);
        show(1, 7'h7F, 2);
        show(1, 7'h7B, 6);
        show(2, 7'h6D, 6);
        expect_frame(16'h3290, 4'b0000);
        show(3, 7'h79, 6);
        idle(4);
        drain("t2");

        // Hex letter A on digit 2
        show(0, 7'h30, 6);
        show(1, 7'h5B, 6);
        show(2, 7'h77, 6);
`ifdef SSEG_READER_HEX_EN
        expect_frame(16'h7A51, 4'b0000);
`else
        expect_frame(16'h7051, 4'b0100);
`endif
        show(3, 7'h70, 6);
        idle(4);
        drain("t3");

        // Two anodes low: no capture, progress on digits 0,1 retained
        show(0, 7'h7E, 6);
        show(1, 7'h30, 6);
        an_n_i = 4'b0011;
        seg_i  = 7'h7E;
        repeat (10) @(negedge clk);
        chk("t4_state_idle", dut.state === S_IDLE, 1);
        chk("t4_seen_kept", dut.seen, 4'b0011);
        drain("t4a");
        show(2, 7'h6D, 6);
        expect_frame(16'h3210, 4'b0000);
        show(3, 7'h79, 6);
        idle(4);
        drain("t4");

        // Mid-frame reset discards captured digits 0,1
        show(0, 7'h5F, 6);
        show(1, 7'h7B, 6);
        rst_n  = 1'b0;
        an_n_i = 4'hF;
        seg_i  = SEG_BLANK;
        #1;
        chk("t5_rst_value", value_o, 0);
        chk("t5_rst_err", digit_err_o, 0);
        chk("t5_rst_fv", frame_valid_o, 0);
        repeat (3) @(negedge clk);
        chk("t5_rst_value_hold", value_o, 0);
        rst_n = 1'b1;
        @(negedge clk);
        show(2, 7'h7F, 6);
        show(3, 7'h30, 6);
        drain("t5a");
        show(0, 7'h33, 6);
        expect_frame(16'h1854, 4'b0000);
        show(1, 7'h5B, 6);
        idle(4);
        drain("t5");

        // Long hold on digit 3 with toggling segments, then back-to-back frame
        show(0, 7'h30, 6);
        show(1, 7'h6D, 6);
        show(2, 7'h79, 6);
        expect_frame(16'h3321, 4'b0000);
        show(3, 7'h79, 6);
        for (int i = 0; i < 44; i++) begin
            seg_i = (i % 2 == 0) ? 7'h30 : SEG_BLANK;
            @(negedge clk);
        end
        chk("t6_state_hold", dut.state === S_HOLD, 1);
        chk("t6_seen_clear", dut.seen, 4'b0000);
        chk("t6_value_a", value_o, 16'h3321);
        show(0, 7'h7B, 6);
        show(1, 7'h7F, 6);
        show(2, 7'h70, 6);
        expect_frame(16'h6789, 4'b0000);
        show(3, 7'h5F, 6);
        idle(6);
        drain("t6");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
